alu_mc: RTL

Multi-cycle, width-parametrised ALU for the datapath. It extends the 3-bit-opcode ALU with a PStart/PDone handshake, a sequential shift-add multiplier that returns the full double-width product, carry/borrow reporting, and a registered zero flag. It sits between operand registers and the writeback stage. The issuing controller waits on PDone before consuming result and extra_result.

---
 rtl/alu_mc.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with PStart/PDone handshake, carry/borrow reporting and a
// sequential shift-add multiplier returning the full double-width product.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PStart,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] extra_result,
    output logic             zero,
    output logic             PDone
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SLR = 3'b111;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]     cnt;

    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] exec_out;

    // Returns {extra_result, result} for every single-cycle opcode.
    function automatic logic [2*WIDTH-1:0] alu_exec(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] x;
        t = '0;
        r = '0;
        x = '0;
        case (op)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[WIDTH-1:0];
                x = WIDTH'(t[WIDTH]);
            end
            OP_SUB: begin
                t = {1'b0, a} - {1'b0, b};
                r = t[WIDTH-1:0];
                x = WIDTH'(t[WIDTH]);
            end
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_NOT: r = ~a;
            OP_SLL: r = (b >= SHIFT_LIM) ? '0 : (a << b);
            OP_SLR: r = (b >= SHIFT_LIM) ? '0 : (a >> b);
            default: r = '0;
        endcase
        return {x, r};
    endfunction

    // The low half of acc starts as the multiplier; each step consumes its LSB
    // while one finished product bit shifts in from the top.
    always_comb begin
        mul_add  = acc[0] ? a_q : '0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        acc_nxt  = {mul_sum, acc[WIDTH-1:1]};
        exec_out = alu_exec(op_q, a_q, b_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            result       <= '0;
            extra_result <= '0;
            zero         <= 1'b1;
            PDone        <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            PDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (PStart) begin
                        a_q  <= inA;
                        b_q  <= inB;
                        op_q <= opcode;
                        if (opcode == OP_MUL) begin
                            acc   <= {{WIDTH{1'b0}}, inB};
                            cnt   <= '0;
                            state <= S_MUL;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    result       <= exec_out[WIDTH-1:0];
                    extra_result <= exec_out[2*WIDTH-1:WIDTH];
                    zero         <= (exec_out[WIDTH-1:0] == '0);
                    PDone        <= 1'b1;
                    state        <= S_IDLE;
                end
                S_MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        result       <= acc_nxt[WIDTH-1:0];
                        extra_result <= acc_nxt[2*WIDTH-1:WIDTH];
                        zero         <= (acc_nxt[WIDTH-1:0] == '0);
                        PDone        <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
